ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 141 ++++++++++++++
 tb/tb_ram_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each accepted command takes three cycles: IDLE (arbitrate), ACCESS (drive RAM), RESP (done).

module ram_arbiter_port #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_gnt,
   input  logic              set_done,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic              gnt,
   output logic              done,
   output logic [DATA_W-1:0] rdata
);

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt   <= 1'b0;
         done  <= 1'b0;
         rdata <= '0;
      end else begin
         gnt  <= set_gnt;
         done <= set_done;
         if (load) rdata <= din;
      end
   end

endmodule

module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              done0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              done1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic              port;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   state_t      state, state_nx;
   cmd_t        cmd;
   logic        last;
   logic        any_req;
   logic        pick;
   logic        accept;
   logic [1:0]  gnt_v, done_v;
   logic [1:0][DATA_W-1:0] rdata_v;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      any_req = req0 | req1;
      pick    = (req0 && req1) ? ~last : req1;
      accept  = (state == IDLE) && any_req;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cmd   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nx;
         if (accept) begin
            cmd.port  <= pick;
            cmd.we    <= pick ? we1    : we0;
            cmd.addr  <= pick ? addr1  : addr0;
            cmd.wdata <= pick ? wdata1 : wdata0;
            last      <= pick;
         end
      end
   end

   // Address/data are the latched command itself, so they hold outside ACCESS.
   assign mem_address = cmd.addr;
   assign mem_data_in = cmd.wdata;
   assign mem_wr      = (state == ACCESS) &&  cmd.we;
   assign mem_rd      = (state == ACCESS) && !cmd.we;
   assign busy        = (state != IDLE);

   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam logic ID = 1'(p);
      ram_arbiter_port #(.DATA_W(DATA_W)) u_port (
         .clk      (clk),
         .rst      (rst),
         .set_gnt  (accept && (pick == ID)),
         .set_done ((state == ACCESS) && (cmd.port == ID)),
         .load     ((state == ACCESS) && (cmd.port == ID) && !cmd.we),
         .din      (mem_data_out),
         .gnt      (gnt_v[p]),
         .done     (done_v[p]),
         .rdata    (rdata_v[p])
      );
   end

   assign gnt0   = gnt_v[0];
   assign gnt1   = gnt_v[1];
   assign done0  = done_v[0];
   assign done1  = done_v[1];
   assign rdata0 = rdata_v[0];
   assign rdata1 = rdata_v[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic, against an
// operation-level model (tie winner, per-port read data, memory contents).
module tb_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, done0, gnt1, done1;
   logic [7:0] rdata0, rdata1;
   logic [7:0] mem_address, mem_data_in, mem_data_out;
   logic       mem_rd, mem_wr, busy;

   int n_chk  = 0;
   int n_fail = 0;

   // environment RAM
   logic [7:0] ram [256] = '{default: 8'h00};
   always @(posedge clk) if (mem_wr) ram[mem_address] <= mem_data_in;
   assign mem_data_out = ram[mem_address];

   // reference model
   logic [7:0] ref_mem [256] = '{default: 8'h00};
   logic [7:0] m_rdata [2];
   int         m_last;

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
      .mem_address(mem_address), .mem_data_in(mem_data_in),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_data_out(mem_data_out),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_gnt"},   {gnt1, gnt0}, 0);
      chk({tag, "_done"},  {done1, done0}, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_memrw"}, {mem_rd, mem_wr}, 0);
      chk({tag, "_rdata"}, {rdata1, rdata0}, 0);
   endtask

   // One complete operation starting in IDLE. keep: winner holds req;
   // poke: scramble winner inputs after grant; rst_mid: reset at the edge ending ACCESS.
   task automatic op(input logic r0, input logic r1,
                     input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                     input bit keep, input bit poke, input bit rst_mid);
      int w;
      logic we;
      logic [7:0] a, d;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      chk("idle_busy", busy, 0);
      chk("idle_memrw", {mem_rd, mem_wr}, 0);
      if (r0 && r1) w = 1 - m_last;
      else          w = r1 ? 1 : 0;
      m_last = w;
      we = (w == 1) ? w1 : w0;
      a  = (w == 1) ? a1 : a0;
      d  = (w == 1) ? d1 : d0;

      tick(); // ACCESS
      chk("acc_gnt", {gnt1, gnt0}, (w == 1) ? 2 : 1);
      chk("acc_done", {done1, done0}, 0);
      chk("acc_busy", busy, 1);
      chk("acc_addr", mem_address, a);
      chk("acc_wr", mem_wr, we);
      chk("acc_rd", mem_rd, !we);
      if (we) chk("acc_wdata", mem_data_in, d);
      if (!keep) begin
         if (w == 1) req1 = 1'b0; else req0 = 1'b0;
      end
      if (poke) begin
         addr0 = 8'd9; addr1 = 8'd9;
         wdata0 = ~wdata0; wdata1 = ~wdata1;
         we0 = ~we0; we1 = ~we1;
      end
      if (rst_mid) begin
         rst = 1'b1;
         tick();
         rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
         if (we) ref_mem[a] = d;
         m_last = 1;
         m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
         chk_reset_outputs("rstmid");
         chk("rstmid_addr", {mem_address, mem_data_in}, 0);
         return;
      end

      tick(); // RESP
      if (we) ref_mem[a] = d;
      else    m_rdata[w] = ref_mem[a];
      chk("resp_done", {done1, done0}, (w == 1) ? 2 : 1);
      chk("resp_gnt", {gnt1, gnt0}, 0);
      chk("resp_busy", busy, 1);
      chk("resp_memrw", {mem_rd, mem_wr}, 0);
      chk("resp_addr_hold", mem_address, a);
      chk("resp_rdata0", rdata0, m_rdata[0]);
      chk("resp_rdata1", rdata1, m_rdata[1]);

      tick(); // back to IDLE
      chk("end_done", {done1, done0}, 0);
      chk("end_busy", busy, 0);
      chk("end_rdata0", rdata0, m_rdata[0]);
      chk("end_rdata1", rdata1, m_rdata[1]);
   endtask

   initial begin
      logic r0, r1;
      rst = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      m_last = 1; m_rdata[0] = 0; m_rdata[1] = 0;
      tick(); tick();
      chk_reset_outputs("reset");
      chk("reset_addr", {mem_address, mem_data_in}, 0);
      rst = 1'b0;

      // write then read back on port 0
      op(1, 0, 1, 8'd3, 8'hA5, 0, 8'd0, 8'd0, 0, 0, 0);
      op(1, 0, 0, 8'd3, 8'h00, 0, 8'd0, 8'd0, 0, 0, 0);
      chk("rd_a5", rdata0, 8'hA5);

      // reset, then simultaneous reads: port 0 first, then port 1
      rst = 1'b1; tick(); rst = 1'b0;
      m_last = 1; m_rdata[0] = 0; m_rdata[1] = 0;
      op(1, 1, 0, 8'd3, 8'h00, 0, 8'd3, 8'h00, 0, 0, 0);
      op(0, 1, 0, 8'd3, 8'h00, 0, 8'd3, 8'h00, 0, 0, 0);
      chk("tie_rdata1", rdata1, 8'hA5);

      // both hold req for four ops: alternating grants, 3-cycle spacing
      for (int i = 0; i < 4; i++)
         op(1, 1, 1, 8'(16 + i), 8'(i), 1, 8'(32 + i), 8'(8'h80 + i), 1, 0, 0);

      // port 1 write 0x3C to addr 7, port 0 reads it
      op(0, 1, 0, 8'd0, 8'd0, 1, 8'd7, 8'h3C, 0, 0, 0);
      op(1, 0, 0, 8'd7, 8'd0, 0, 8'd0, 8'd0, 0, 0, 0);
      chk("x_rdata0", rdata0, 8'h3C);

      // address change after grant does not disturb a read of addr 2
      op(0, 1, 1, 8'd0, 8'd0, 1, 8'd2, 8'h5E, 0, 0, 0);
      op(1, 0, 0, 8'd2, 8'd0, 0, 8'd0, 8'd0, 0, 1, 0);
      chk("poke_rdata0", rdata0, 8'h5E);

      // reset at the end of a read's ACCESS: abandoned, no done
      op(1, 0, 0, 8'd2, 8'd0, 0, 8'd0, 8'd0, 0, 0, 1);
      tick();
      chk_reset_outputs("after_rst_read");
      // reset coinciding with a write's ACCESS still commits the write
      op(0, 1, 0, 8'd0, 8'd0, 1, 8'h20, 8'h77, 0, 0, 1);
      op(1, 1, 0, 8'h20, 8'd0, 0, 8'h20, 8'd0, 0, 0, 0);
      chk("rst_write_commit", rdata0, 8'h77);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         r0 = 1'($urandom_range(0, 1));
         r1 = 1'($urandom_range(0, 1));
         if (!r0 && !r1) r0 = 1'b1;
         op(r0, r1,
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
